// File: rtl/tlb_defines.sv
// Shared definitions for the TLB maintenance sequencer.
// Holds the op_type encoding, INVTLB op constants, the default entry count
// and the FSM state encoding.
package tlb_defines;

  localparam int unsigned TLBNUM   = 16;
  localparam int unsigned ASID_W   = 10;
  localparam int unsigned VPPN_W   = 19;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned INV_OP_W = 5;

  // Committed TLB instruction encoding; 5-7 are reserved
  typedef enum logic [OP_W-1:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_e;

  // INVTLB op field values
  localparam logic [INV_OP_W-1:0] INV_ALL0         = 5'd0;
  localparam logic [INV_OP_W-1:0] INV_ALL1         = 5'd1;
  localparam logic [INV_OP_W-1:0] INV_G1           = 5'd2;
  localparam logic [INV_OP_W-1:0] INV_G0           = 5'd3;
  localparam logic [INV_OP_W-1:0] INV_G0_ASID      = 5'd4;
  localparam logic [INV_OP_W-1:0] INV_G0_ASID_VA   = 5'd5;
  localparam logic [INV_OP_W-1:0] INV_G_OR_ASID_VA = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_WALK    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/tlb_entry_match.sv
// Combinational comparator for one TLB entry read back from the array.
// Inputs : entry E/G/ASID/VPPN/PS4M, operand ASID/VPPN, INVTLB op.
// Outputs: srch_hit (TLBSRCH hit), inv_hit (entry selected by INVTLB op).
module tlb_entry_match
  import tlb_defines::*;
(
  input  logic                ent_e,
  input  logic                ent_g,
  input  logic [ASID_W-1:0]   ent_asid,
  input  logic [VPPN_W-1:0]   ent_vppn,
  input  logic                ent_ps4m,
  input  logic [ASID_W-1:0]   op_asid,
  input  logic [VPPN_W-1:0]   op_vppn,
  input  logic [INV_OP_W-1:0] inv_op,
  output logic                srch_hit,
  output logic                inv_hit
);

  logic asid_eq;
  logic vppn_eq;

  assign asid_eq = (ent_asid == op_asid);
  // 4MB pages ignore the low 9 VPPN bits
  assign vppn_eq = ent_ps4m ? (ent_vppn[VPPN_W-1:9] == op_vppn[VPPN_W-1:9])
                            : (ent_vppn == op_vppn);

  assign srch_hit = ent_e && (ent_g || asid_eq) && vppn_eq;

  // E is deliberately not part of the INVTLB selection
  always_comb begin
    inv_hit = 1'b0;
    case (inv_op)
      INV_ALL0, INV_ALL1: inv_hit = 1'b1;
      INV_G1:             inv_hit = ent_g;
      INV_G0:             inv_hit = !ent_g;
      INV_G0_ASID:        inv_hit = !ent_g && asid_eq;
      INV_G0_ASID_VA:     inv_hit = !ent_g && asid_eq && vppn_eq;
      INV_G_OR_ASID_VA:   inv_hit = (ent_g || asid_eq) && vppn_eq;
      default:            inv_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_maint_seq.sv
// Commit-side sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
// Owns the TLB array read/write port and stalls commit while an op runs.
// Ports: op_valid/op_type/op_ready handshake, INVTLB operands, CSR sources
// (csr_index/asid/vppn), array read port (tlb_rd_*), array write port
// (tlb_we/tlb_w_idx/tlb_w_clr), status busy/done/srch_found/srch_index/rd_done.
module tlb_maint_seq
  import tlb_defines::*;
#(
  parameter int unsigned TLBNUM = tlb_defines::TLBNUM,
  parameter int unsigned IDX_W  = $clog2(TLBNUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [OP_W-1:0]     op_type,
  output logic                op_ready,
  input  logic [INV_OP_W-1:0] inv_op,
  input  logic [ASID_W-1:0]   inv_asid,
  input  logic [VPPN_W-1:0]   inv_vppn,
  input  logic [IDX_W-1:0]    csr_index,
  input  logic [ASID_W-1:0]   csr_asid,
  input  logic [VPPN_W-1:0]   csr_vppn,
  output logic                tlb_rd_en,
  output logic [IDX_W-1:0]    tlb_rd_idx,
  input  logic                tlb_rd_e,
  input  logic                tlb_rd_g,
  input  logic [ASID_W-1:0]   tlb_rd_asid,
  input  logic [VPPN_W-1:0]   tlb_rd_vppn,
  input  logic                tlb_rd_ps4m,
  output logic                tlb_we,
  output logic [IDX_W-1:0]    tlb_w_idx,
  output logic                tlb_w_clr,
  output logic                busy,
  output logic                done,
  output logic                srch_found,
  output logic [IDX_W-1:0]    srch_index,
  output logic                rd_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  state_e               state_q, state_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [INV_OP_W-1:0]  inv_op_q, inv_op_d;
  logic [ASID_W-1:0]    op_asid_q, op_asid_d;
  logic [VPPN_W-1:0]    op_vppn_q, op_vppn_d;
  logic [IDX_W-1:0]     fill_cnt_q;
  logic                 eval_vld_q;
  logic [IDX_W-1:0]     eval_idx_q;
  logic                 we_q, we_d;
  logic [IDX_W-1:0]     w_idx_q, w_idx_d;
  logic                 rd_en_d;
  logic [IDX_W-1:0]     rd_idx_d;
  logic                 done_d, rd_done_d, busy_d, op_ready_d;
  logic                 found_d;
  logic [IDX_W-1:0]     found_idx_d;
  logic                 srch_hit, inv_hit;
  logic                 inv_we_c;

  // Per-entry compare on the data returned for the read issued last cycle
  tlb_entry_match u_match (
    .ent_e    (tlb_rd_e),
    .ent_g    (tlb_rd_g),
    .ent_asid (tlb_rd_asid),
    .ent_vppn (tlb_rd_vppn),
    .ent_ps4m (tlb_rd_ps4m),
    .op_asid  (op_asid_q),
    .op_vppn  (op_vppn_q),
    .inv_op   (inv_op_q),
    .srch_hit (srch_hit),
    .inv_hit  (inv_hit)
  );

  // INVTLB clears land in the evaluation cycle, so this path is combinational
  assign inv_we_c  = (state_q == ST_WALK) && (op_q == OP_INV) && eval_vld_q && inv_hit;
  assign tlb_we    = we_q | inv_we_c;
  assign tlb_w_idx = inv_we_c ? eval_idx_q : w_idx_q;
  assign tlb_w_clr = inv_we_c;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    inv_op_d    = inv_op_q;
    op_asid_d   = op_asid_q;
    op_vppn_d   = op_vppn_q;
    rd_en_d     = 1'b0;
    rd_idx_d    = tlb_rd_idx;
    we_d        = 1'b0;
    w_idx_d     = w_idx_q;
    done_d      = 1'b0;
    rd_done_d   = 1'b0;
    found_d     = srch_found;
    found_idx_d = srch_index;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready) begin
          op_d        = op_type;
          inv_op_d    = inv_op;
          op_asid_d   = (op_type == OP_INV) ? inv_asid : csr_asid;
          op_vppn_d   = (op_type == OP_INV) ? inv_vppn : csr_vppn;
          found_d     = 1'b0;
          found_idx_d = '0;
          case (op_type)
            OP_SRCH, OP_INV: begin
              rd_en_d  = 1'b1;
              rd_idx_d = '0;
              state_d  = ST_WALK;
            end
            OP_RD: begin
              rd_en_d  = 1'b1;
              rd_idx_d = csr_index;
              state_d  = ST_RD;
            end
            OP_WR: begin
              we_d    = 1'b1;
              w_idx_d = csr_index;
              state_d = ST_WRITE;
            end
            OP_FILL: begin
              we_d    = 1'b1;
              w_idx_d = fill_cnt_q;
              state_d = ST_WRITE;
            end
            default: begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_RD: begin
        rd_done_d = 1'b1;
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT, ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_WALK: begin
        // Issue the next read while the previous entry is being evaluated
        if (tlb_rd_en && (tlb_rd_idx != LAST_IDX)) begin
          rd_en_d  = 1'b1;
          rd_idx_d = tlb_rd_idx + IDX_W'(1);
        end
        if ((op_q == OP_SRCH) && eval_vld_q && srch_hit) begin
          rd_en_d     = 1'b0;
          found_d     = 1'b1;
          found_idx_d = eval_idx_q;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else if (eval_vld_q && (eval_idx_q == LAST_IDX)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    op_ready_d = (state_d == ST_IDLE);
    // Stall is released in the completion cycle so commit can advance on done
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // State, operand and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      inv_op_q   <= '0;
      op_asid_q  <= '0;
      op_vppn_q  <= '0;
      fill_cnt_q <= '0;
      eval_vld_q <= 1'b0;
      eval_idx_q <= '0;
      we_q       <= 1'b0;
      w_idx_q    <= '0;
      tlb_rd_en  <= 1'b0;
      tlb_rd_idx <= '0;
      op_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_done    <= 1'b0;
      srch_found <= 1'b0;
      srch_index <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      inv_op_q   <= inv_op_d;
      op_asid_q  <= op_asid_d;
      op_vppn_q  <= op_vppn_d;
      fill_cnt_q <= fill_cnt_q + IDX_W'(1);
      eval_vld_q <= (state_q == ST_WALK) && tlb_rd_en;
      eval_idx_q <= tlb_rd_idx;
      we_q       <= we_d;
      w_idx_q    <= w_idx_d;
      tlb_rd_en  <= rd_en_d;
      tlb_rd_idx <= rd_idx_d;
      op_ready   <= op_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      rd_done    <= rd_done_d;
      srch_found <= found_d;
      srch_index <= found_idx_d;
    end
  end

endmodule

// File: tb/tb_tlb_maint_seq.sv
// Directed self-checking bench for tlb_maint_seq with a registered-read
// TLB array model.
module tb_tlb_maint_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_type;
  logic        op_ready;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic [3:0]  csr_index;
  logic [9:0]  csr_asid;
  logic [18:0] csr_vppn;
  logic        tlb_rd_en;
  logic [3:0]  tlb_rd_idx;
  logic        tlb_rd_e;
  logic        tlb_rd_g;
  logic [9:0]  tlb_rd_asid;
  logic [18:0] tlb_rd_vppn;
  logic        tlb_rd_ps4m;
  logic        tlb_we;
  logic [3:0]  tlb_w_idx;
  logic        tlb_w_clr;
  logic        busy;
  logic        done;
  logic        srch_found;
  logic [3:0]  srch_index;
  logic        rd_done;

  logic        e_m    [16];
  logic        g_m    [16];
  logic [9:0]  asid_m [16];
  logic [18:0] vppn_m [16];
  logic        ps_m   [16];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  tlb_maint_seq dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .csr_index(csr_index), .csr_asid(csr_asid), .csr_vppn(csr_vppn),
    .tlb_rd_en(tlb_rd_en), .tlb_rd_idx(tlb_rd_idx),
    .tlb_rd_e(tlb_rd_e), .tlb_rd_g(tlb_rd_g), .tlb_rd_asid(tlb_rd_asid),
    .tlb_rd_vppn(tlb_rd_vppn), .tlb_rd_ps4m(tlb_rd_ps4m),
    .tlb_we(tlb_we), .tlb_w_idx(tlb_w_idx), .tlb_w_clr(tlb_w_clr),
    .busy(busy), .done(done), .srch_found(srch_found),
    .srch_index(srch_index), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  // Array model: data appears one cycle after the read strobe
  always @(posedge clk) begin
    if (tlb_rd_en) begin
      tlb_rd_e    <= e_m[tlb_rd_idx];
      tlb_rd_g    <= g_m[tlb_rd_idx];
      tlb_rd_asid <= asid_m[tlb_rd_idx];
      tlb_rd_vppn <= vppn_m[tlb_rd_idx];
      tlb_rd_ps4m <= ps_m[tlb_rd_idx];
    end
  end

  // Cycles since reset release; tracks the expected free-running fill counter
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op for one cycle; returns after the accepting edge (accept+1)
  task automatic issue(input logic [2:0] t);
    op_valid = 1'b1;
    op_type  = t;
    tick();
    op_valid = 1'b0;
  endtask

  // Cycles after accept until done, tracking writes; n=0 if budget expires.
  // Caller is already at accept+1.
  task automatic track(output int n, output int wcnt, output logic [3:0] first_idx,
                       output int first_cyc, output logic all_clr);
    n = 0; wcnt = 0; first_idx = '0; first_cyc = 0; all_clr = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (tlb_we) begin
        if (wcnt == 0) begin
          first_idx = tlb_w_idx;
          first_cyc = i;
        end
        wcnt++;
        all_clr = all_clr & tlb_w_clr;
      end
      if (done) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !op_ready; i++) tick();
    chk("back_to_idle", 32'(op_ready), 32'd1);
  endtask

  int         n, wcnt, fcyc, c1, c2;
  logic [3:0] fidx, idx1, idx2;
  logic       aclr;

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_type = '0; inv_op = '0; inv_asid = '0;
    inv_vppn = '0; csr_index = '0; csr_asid = '0; csr_vppn = '0;
    for (int i = 0; i < 16; i++) begin
      e_m[i] = 1'b0; g_m[i] = 1'b0; asid_m[i] = '0; vppn_m[i] = '0; ps_m[i] = 1'b0;
    end
    tick(); tick();
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(tlb_we), 32'd0);
    chk("rst_rd_en", 32'(tlb_rd_en), 32'd0);
    chk("rst_found", 32'(srch_found), 32'd0);
    rst = 1'b0;
    tick();

    // TLBWR to index 5
    csr_index = 4'd5;
    issue(3'd2);
    chk("wr_we", 32'(tlb_we), 32'd1);
    chk("wr_idx", 32'(tlb_w_idx), 32'd5);
    chk("wr_clr", 32'(tlb_w_clr), 32'd0);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_ready", 32'(op_ready), 32'd0);
    tick();
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_busy_done", 32'(busy), 32'd0);
    chk("wr_we_off", 32'(tlb_we), 32'd0);
    tick();
    chk("wr_idle", 32'(op_ready), 32'd1);

    // TLBRD from index 7
    e_m[7] = 1'b1; asid_m[7] = 10'h155; vppn_m[7] = 19'h0abcd;
    csr_index = 4'd7;
    issue(3'd1);
    chk("rd_en", 32'(tlb_rd_en), 32'd1);
    chk("rd_idx", 32'(tlb_rd_idx), 32'd7);
    chk("rd_done_early", 32'(rd_done), 32'd0);
    tick();
    chk("rd_done", 32'(rd_done), 32'd1);
    chk("rd_asid_data", 32'(tlb_rd_asid), 32'h155);
    tick();
    chk("rd_fin", 32'(done), 32'd1);
    wait_idle();

    // TLBSRCH: entries 4 and 9 hit, entry 1 same VA other ASID
    for (int i = 0; i < 16; i++) vppn_m[i] = 19'h00001;
    e_m[4] = 1'b1; asid_m[4] = 10'd3; vppn_m[4] = 19'h12345;
    e_m[9] = 1'b1; asid_m[9] = 10'd3; vppn_m[9] = 19'h12345;
    e_m[1] = 1'b1; asid_m[1] = 10'd5; vppn_m[1] = 19'h12345;
    csr_vppn = 19'h12345; csr_asid = 10'd3;
    issue(3'd0);
    chk("srch_rd_en0", 32'(tlb_rd_en), 32'd1);
    chk("srch_rd_idx0", 32'(tlb_rd_idx), 32'd0);
    track(n, wcnt, fidx, fcyc, aclr);
    chk("srch_done_cyc", 32'(n), 32'd7);
    chk("srch_found", 32'(srch_found), 32'd1);
    chk("srch_index", 32'(srch_index), 32'd4);
    chk("srch_no_write", 32'(wcnt), 32'd0);
    tick();
    chk("srch_hold", 32'(srch_index), 32'd4);

    // TLBSRCH on a 4MB page: low 9 VPPN bits ignored
    e_m[4] = 1'b0; e_m[9] = 1'b0; e_m[1] = 1'b0;
    e_m[2] = 1'b1; g_m[2] = 1'b1; vppn_m[2] = 19'h12200; ps_m[2] = 1'b1;
    csr_vppn = 19'h123FF;
    wait_idle();
    issue(3'd0);
    chk("srch_clr_at_accept", 32'(srch_found), 32'd0);
    track(n, wcnt, fidx, fcyc, aclr);
    chk("ps4m_done_cyc", 32'(n), 32'd5);
    chk("ps4m_found", 32'(srch_found), 32'd1);
    chk("ps4m_index", 32'(srch_index), 32'd2);

    // Same target against a 4KB page: full miss, worst-case walk
    ps_m[2] = 1'b0;
    wait_idle();
    issue(3'd0);
    track(n, wcnt, fidx, fcyc, aclr);
    chk("miss_done_cyc", 32'(n), 32'd18);
    chk("miss_found", 32'(srch_found), 32'd0);
    wait_idle();

    // INVTLB op 5: only G=0/ASID/VA entry 3 cleared, G=1 entry 6 skipped
    g_m[3] = 1'b0; asid_m[3] = 10'd7; vppn_m[3] = 19'h00400;
    g_m[6] = 1'b1; asid_m[6] = 10'd0; vppn_m[6] = 19'h00400;
    inv_op = 5'd5; inv_asid = 10'd7; inv_vppn = 19'h00400;
    issue(3'd4);
    track(n, wcnt, fidx, fcyc, aclr);
    chk("inv5_done_cyc", 32'(n), 32'd18);
    chk("inv5_wcnt", 32'(wcnt), 32'd1);
    chk("inv5_idx", 32'(fidx), 32'd3);
    chk("inv5_wcyc", 32'(fcyc), 32'd5);
    chk("inv5_clr", 32'(aclr), 32'd1);
    wait_idle();

    // INVTLB op 2: G=1 entries are 2 and 6
    inv_op = 5'd2;
    issue(3'd4);
    track(n, wcnt, fidx, fcyc, aclr);
    chk("inv2_wcnt", 32'(wcnt), 32'd2);
    chk("inv2_first", 32'(fidx), 32'd2);
    chk("inv2_done_cyc", 32'(n), 32'd18);
    wait_idle();

    // Reserved op_type goes straight to completion
    issue(3'd6);
    chk("rsv_done", 32'(done), 32'd1);
    chk("rsv_we", 32'(tlb_we), 32'd0);
    wait_idle();

    // Two TLBFILLs accepted 3 cycles apart
    c1 = cyc;
    issue(3'd3);
    idx1 = tlb_w_idx;
    chk("fill1_we", 32'(tlb_we), 32'd1);
    chk("fill1_idx", 32'(idx1), 32'(c1 % 16));
    tick(); tick();
    c2 = cyc;
    issue(3'd3);
    idx2 = tlb_w_idx;
    chk("fill2_gap", 32'(c2 - c1), 32'd3);
    chk("fill2_idx_delta", 32'(4'(idx2 - idx1)), 32'd3);
    chk("fill2_clr", 32'(tlb_w_clr), 32'd0);
    wait_idle();

    // Reset in the middle of an INVTLB-all walk
    inv_op = 5'd0;
    issue(3'd4);
    tick(); tick(); tick();
    chk("midwalk_we", 32'(tlb_we), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstwalk_we", 32'(tlb_we), 32'd0);
    chk("rstwalk_ready", 32'(op_ready), 32'd1);
    chk("rstwalk_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("postrst_we", 32'(tlb_we), 32'd0);
    chk("postrst_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
